// File: rtl/prep_scheduler_if.sv
// Handshake bundle between the edit/frame logic and the prep scheduler.
// Define PREP_STATS_EN to add the stat_cnt pass statistic.
interface prep_scheduler_if #(
  parameter int MAXSHP = 16,
  parameter int IDW    = $clog2(MAXSHP)
);
  logic              frame_end;
  logic              full_sweep;
  logic [MAXSHP-1:0] dirty_set;
  logic              busy;
  logic [IDW-1:0]    req_id;
  logic              ld;
  logic              wr;
  logic              done;
  logic [MAXSHP-1:0] dirty;
`ifdef PREP_STATS_EN
  logic [IDW:0]      stat_cnt;

  modport master (
    output frame_end, full_sweep, dirty_set,
    input  busy, req_id, ld, wr, done, dirty, stat_cnt
  );
  modport slave (
    input  frame_end, full_sweep, dirty_set,
    output busy, req_id, ld, wr, done, dirty, stat_cnt
  );
`else
  modport master (
    output frame_end, full_sweep, dirty_set,
    input  busy, req_id, ld, wr, done, dirty
  );
  modport slave (
    input  frame_end, full_sweep, dirty_set,
    output busy, req_id, ld, wr, done, dirty
  );
`endif
endinterface

// File: rtl/prep_scheduler.sv
// Runs the shared trig/rotate prep datapath once per frame over only the dirty shape slots.
// Define PREP_STATS_EN to count slots written back in the last completed pass (stat_cnt).
module prep_scheduler #(
  parameter int MAXSHP = 16,
  parameter int IDW    = $clog2(MAXSHP),
  parameter int LAT    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  prep_scheduler_if.slave  bus
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SCAN  = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_FIN   = 3'd5;

  logic [2:0]        r_state;
  logic              r_busy;
  logic [IDW-1:0]    r_reqId;
  logic [CW-1:0]     r_cnt;
  logic [MAXSHP-1:0] r_pend;
  logic [MAXSHP-1:0] r_dirty;
  logic              w_found;
  logic [IDW-1:0]    w_idx;
`ifdef PREP_STATS_EN
  logic [IDW:0]      r_wrCnt;
  logic [IDW:0]      r_statCnt;
`endif

  // Lowest pending slot wins, giving ascending visit order within a pass.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = MAXSHP - 1; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_found = 1'b1;
        w_idx   = IDW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_reqId <= '0;
      r_cnt   <= '0;
      r_pend  <= '0;
      r_dirty <= '1;
`ifdef PREP_STATS_EN
      r_wrCnt   <= '0;
      r_statCnt <= '0;
`endif
    end else begin
      r_dirty <= r_dirty | bus.dirty_set;
      case (r_state)
        S_IDLE: begin
          // Snapshot cycle: edits arriving now go straight into this pass.
          if (bus.frame_end) begin
            r_pend  <= r_dirty | bus.dirty_set | {MAXSHP{bus.full_sweep}};
            r_dirty <= '0;
            r_busy  <= 1'b1;
            r_state <= S_SCAN;
`ifdef PREP_STATS_EN
            r_wrCnt <= '0;
`endif
          end
        end
        S_SCAN: begin
          if (w_found) begin
            r_reqId <= w_idx;
            r_state <= S_LOAD;
          end else begin
            r_state <= S_FIN;
`ifdef PREP_STATS_EN
            r_statCnt <= r_wrCnt;
`endif
          end
        end
        S_LOAD: begin
          r_pend[r_reqId] <= 1'b0;
          r_cnt           <= '0;
          r_state         <= S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(LAT - 1)) r_state <= S_WRITE;
        end
        S_WRITE: begin
          r_state <= S_SCAN;
`ifdef PREP_STATS_EN
          if (r_wrCnt != (IDW + 1)'(MAXSHP)) r_wrCnt <= r_wrCnt + 1'b1;
`endif
        end
        S_FIN: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.req_id = r_reqId;
  assign bus.ld     = (r_state == S_LOAD);
  assign bus.wr     = (r_state == S_WRITE);
  assign bus.done   = (r_state == S_FIN);
  assign bus.dirty  = r_dirty;
`ifdef PREP_STATS_EN
  assign bus.stat_cnt = r_statCnt;
`endif

endmodule

// File: tb/tb_prep_scheduler.sv
// Directed bench for prep_scheduler: a pass-schedule model checked every cycle plus literal pins.
// Honours PREP_STATS_EN for the stat_cnt checks.
module tb_prep_scheduler;
  localparam int MAXSHP = 16;
  localparam int LAT    = 4;
  localparam int P      = LAT + 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors  = 0;
  int   checks  = 0;
  int   cycleNo = 0;
  int   obsLd[$];

  prep_scheduler_if #(.MAXSHP(MAXSHP)) bus ();

  prep_scheduler #(.MAXSHP(MAXSHP), .LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycleNo <= cycleNo + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cycleNo);
    end
  endtask

  task automatic applyStimulus(input logic fe, input logic fs, input logic [MAXSHP-1:0] ds);
    @(posedge clk);
    #2;
    bus.frame_end  = fe;
    bus.full_sweep = fs;
    bus.dirty_set  = ds;
  endtask

  task automatic waitDone(input int maxCyc, output int doneCyc);
    bit found = 0;
    doneCyc = -1;
    for (int i = 0; i < maxCyc && !found; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        found   = 1;
        doneCyc = cycleNo;
      end
    end
    if (!found) checkOutput("doneTimeout", 32'd0, 32'd1);
  endtask

  task automatic waitLd(input int id, input int maxCyc);
    bit found = 0;
    for (int i = 0; i < maxCyc && !found; i++) begin
      @(negedge clk);
      if (bus.ld === 1'b1 && bus.req_id == id[3:0]) found = 1;
    end
    if (!found) checkOutput("ldTimeout", 32'd0, 32'd1);
  endtask

  // Model: a pass is a list of slot ids; each costs P cycles after one initial SCAN cycle.
  bit          mBusy  = 0;
  logic [3:0]  mReq   = '0;
  logic [15:0] mDirty = '1;
  int          mIds[MAXSHP];
  int          mN     = 0;
  int          mStart = 0;
  int          mCyc   = 0;
  int          mStat  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mBusy  = 0;
      mReq   = '0;
      mDirty = '1;
      mStat  = 0;
    end else begin
      if (!mBusy && bus.frame_end) begin
        logic [15:0] pend;
        pend   = mDirty | bus.dirty_set | (bus.full_sweep ? 16'hFFFF : 16'h0000);
        mDirty = '0;
        mN     = 0;
        for (int i = 0; i < MAXSHP; i++) if (pend[i]) begin
          mIds[mN] = i;
          mN++;
        end
        mStart = mCyc + 1;
        mBusy  = 1;
      end else begin
        mDirty = mDirty | bus.dirty_set;
        if (mBusy && (mCyc - mStart) == mN * P + 1) begin
          mBusy = 0;
          if (mN > 0) mReq = mIds[mN-1][3:0];
          mStat = mN;
        end
      end
      mCyc++;
    end
  end

  always @(negedge clk) begin
    logic       eBusy, eLd, eWr, eDone;
    logic [3:0] eReq;
    int         eStat, off, k, r;
    eBusy = mBusy;
    eLd = 0; eWr = 0; eDone = 0;
    eReq  = mReq;
    eStat = mStat;
    if (mBusy) begin
      off = mCyc - mStart;
      k   = off / P;
      r   = off % P;
      eLd   = (k < mN) && (r == 1);
      eWr   = (k < mN) && (r == LAT + 2);
      eDone = (off == mN * P + 1);
      if (k < mN && r >= 1) eReq = mIds[k][3:0];
      else if (k > 0)       eReq = mIds[k-1][3:0];
      if (eDone) eStat = mN;
    end
    checkOutput("busy",   {31'd0, bus.busy},   {31'd0, eBusy});
    checkOutput("ld",     {31'd0, bus.ld},     {31'd0, eLd});
    checkOutput("wr",     {31'd0, bus.wr},     {31'd0, eWr});
    checkOutput("done",   {31'd0, bus.done},   {31'd0, eDone});
    checkOutput("req_id", {28'd0, bus.req_id}, {28'd0, eReq});
    checkOutput("dirty",  {16'd0, bus.dirty},  {16'd0, mDirty});
`ifdef PREP_STATS_EN
    checkOutput("stat_cnt", {27'd0, bus.stat_cnt}, eStat);
`endif
  end

  always @(negedge clk) if (rst_n && bus.ld === 1'b1) obsLd.push_back(int'(bus.req_id));

  initial begin
    int feCyc, doneCyc;
    bus.frame_end  = 1'b0;
    bus.full_sweep = 1'b0;
    bus.dirty_set  = '0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("resetDirty", {16'd0, bus.dirty}, 32'h0000FFFF);
    checkOutput("resetBusy",  {31'd0, bus.busy},  32'd0);
    rst_n = 1'b1;

    $display("[TB] initial full pass");
    obsLd.delete();
    applyStimulus(1, 0, '0);
    applyStimulus(0, 0, '0);
    waitDone(300, doneCyc);
    checkOutput("pass1Count", obsLd.size(), 32'd16);
    for (int i = 0; i < obsLd.size(); i++) checkOutput("pass1Order", obsLd[i], i);
`ifdef PREP_STATS_EN
    checkOutput("pass1Stat", {27'd0, bus.stat_cnt}, 32'd16);
`endif

    $display("[TB] empty pass");
    obsLd.delete();
    applyStimulus(1, 0, '0);
    feCyc = cycleNo;
    applyStimulus(0, 0, '0);
    waitDone(20, doneCyc);
    checkOutput("emptyLatency", doneCyc - feCyc, 32'd2);
    checkOutput("emptyCount", obsLd.size(), 32'd0);

    $display("[TB] sparse edits 2 and 5");
    applyStimulus(0, 0, 16'h0024);
    applyStimulus(0, 0, '0);
    @(negedge clk);
    checkOutput("sparseDirty", {16'd0, bus.dirty}, 32'h00000024);
    obsLd.delete();
    applyStimulus(1, 0, '0);
    applyStimulus(0, 0, '0);
    waitDone(100, doneCyc);
    checkOutput("sparseCount", obsLd.size(), 32'd2);
    if (obsLd.size() == 2) begin
      checkOutput("sparseFirst",  obsLd[0], 32'd2);
      checkOutput("sparseSecond", obsLd[1], 32'd5);
    end
    checkOutput("sparseDirtyAfter", {16'd0, bus.dirty}, 32'd0);
`ifdef PREP_STATS_EN
    checkOutput("sparseStat", {27'd0, bus.stat_cnt}, 32'd2);
`endif

    $display("[TB] re-edit of slot 3 during its WAIT");
    applyStimulus(0, 0, 16'h0008);
    applyStimulus(1, 0, '0);
    applyStimulus(0, 0, '0);
    waitLd(3, 50);
    applyStimulus(0, 0, 16'h0008);
    applyStimulus(0, 0, '0);
    waitDone(100, doneCyc);
    checkOutput("reeditDirty", {16'd0, bus.dirty}, 32'h00000008);

    $display("[TB] frame_end while busy, then full sweep");
    obsLd.delete();
    applyStimulus(1, 0, '0);
    applyStimulus(0, 0, '0);
    repeat (3) applyStimulus(0, 0, '0);
    applyStimulus(1, 0, '0);
    applyStimulus(0, 0, '0);
    waitDone(100, doneCyc);
    checkOutput("busyPassCount", obsLd.size(), 32'd1);
    if (obsLd.size() == 1) checkOutput("busyPassId", obsLd[0], 32'd3);
    repeat (3) applyStimulus(0, 0, '0);
    checkOutput("noQueuedPass", {31'd0, bus.busy}, 32'd0);
    obsLd.delete();
    applyStimulus(1, 1, '0);
    applyStimulus(0, 0, '0);
    waitDone(300, doneCyc);
    checkOutput("sweepCount", obsLd.size(), 32'd16);

    $display("[TB] reset during WAIT");
    applyStimulus(1, 1, '0);
    applyStimulus(0, 0, '0);
    waitLd(2, 100);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abortBusy",  {31'd0, bus.busy},   32'd0);
    checkOutput("abortLd",    {31'd0, bus.ld},     32'd0);
    checkOutput("abortWr",    {31'd0, bus.wr},     32'd0);
    checkOutput("abortDone",  {31'd0, bus.done},   32'd0);
    checkOutput("abortReq",   {28'd0, bus.req_id}, 32'd0);
    checkOutput("abortDirty", {16'd0, bus.dirty},  32'h0000FFFF);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    obsLd.delete();
    applyStimulus(1, 0, '0);
    applyStimulus(0, 0, '0);
    waitDone(300, doneCyc);
    checkOutput("postResetCount", obsLd.size(), 32'd16);
`ifdef PREP_STATS_EN
    checkOutput("postResetStat", {27'd0, bus.stat_cnt}, 32'd16);
`endif

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
